// File: rtl/pc_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// pc_fetch_sequencer
//
// Instruction fetch sequencer. Keeps a program counter, issues one
// instruction-memory request at a time, and presents each returned word to
// decode with its address. Redirects (jumps) are accepted in every state. A
// jump during an outstanding request lets the request finish and throws its
// data away, then fetches from the new target.
//
// Ports
//   clk            clock, rising-edge
//   n_rst          asynchronous active-low reset
//   i_en           run enable; gates issuing of new requests
//   i_jump         redirect request, sampled every rising edge
//   i_jump_addr    redirect target, valid with i_jump
//   o_mem_req      instruction-memory request (registered)
//   o_mem_addr     fetch address (registered)
//   i_mem_ack      memory completion, meaningful while o_mem_req=1
//   i_mem_data     instruction word, valid with i_mem_ack
//   o_instr_valid  instruction presented to decode (registered)
//   o_instr        presented instruction (registered)
//   o_instr_pc     address of presented instruction (registered)
//   i_instr_ready  decode accepts; transfer on valid & ready at a rising edge
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no request, nothing presented; waits for i_en
// FETCH  | o_mem_req high, o_mem_addr frozen until i_mem_ack
// HOLD   | instruction presented, waits for transfer or a jump
// -----------------------------------------------------------------------------
module pc_fetch_sequencer #(
   parameter int unsigned      WIDTH      = 32,
   parameter int unsigned      IWIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              i_en,
   input  logic              i_jump,
   input  logic [WIDTH-1:0]  i_jump_addr,
   output logic              o_mem_req,
   output logic [WIDTH-1:0]  o_mem_addr,
   input  logic              i_mem_ack,
   input  logic [IWIDTH-1:0] i_mem_data,
   output logic              o_instr_valid,
   output logic [IWIDTH-1:0] o_instr,
   output logic [WIDTH-1:0]  o_instr_pc,
   input  logic              i_instr_ready
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [WIDTH-1:0]    pc_q, pc_d;
   logic                mem_req_q, mem_req_d;
   logic [WIDTH-1:0]    mem_addr_q, mem_addr_d;
   logic                instr_valid_q, instr_valid_d;
   logic [IWIDTH-1:0]   instr_q, instr_d;
   logic [WIDTH-1:0]    instr_pc_q, instr_pc_d;
   logic                squash_q, squash_d;

   logic [WIDTH-1:0]    redirect;
   logic                xfer;

   // pc_q always holds the address of the next fetch to issue. While a
   // request is in flight it is overwritten by any jump target, so the
   // last sampled target wins without a separate target register.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      mem_req_d     = mem_req_q;
      mem_addr_d    = mem_addr_q;
      instr_valid_d = instr_valid_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      squash_d      = squash_q;

      redirect = i_jump ? i_jump_addr : pc_q;
      xfer     = instr_valid_q & i_instr_ready;

      unique case (state_q)
         ST_IDLE: begin
            pc_d = redirect;
            if (i_en) begin
               state_d    = ST_FETCH;
               mem_req_d  = 1'b1;
               mem_addr_d = redirect;
            end
         end

         ST_FETCH: begin
            pc_d = redirect;
            if (i_jump) begin
               squash_d = 1'b1;
            end
            if (i_mem_ack) begin
               squash_d = 1'b0;
               if (squash_q || i_jump) begin
                  // Stale data: drop it and restart straight at the target.
                  if (i_en) begin
                     mem_addr_d = redirect;
                  end else begin
                     state_d   = ST_IDLE;
                     mem_req_d = 1'b0;
                  end
               end else begin
                  instr_d       = i_mem_data;
                  instr_pc_d    = mem_addr_q;
                  instr_valid_d = 1'b1;
                  mem_req_d     = 1'b0;
                  pc_d          = mem_addr_q + WIDTH'(1);
                  state_d       = ST_HOLD;
               end
            end
         end

         ST_HOLD: begin
            // A transfer and a jump both end the hold; with a jump and no
            // transfer the presented instruction is simply dropped.
            if (xfer || i_jump) begin
               instr_valid_d = 1'b0;
               pc_d          = redirect;
               if (i_en) begin
                  state_d    = ST_FETCH;
                  mem_req_d  = 1'b1;
                  mem_addr_d = redirect;
               end else begin
                  state_d    = ST_IDLE;
               end
            end
         end

         default: begin
            state_d       = ST_IDLE;
            mem_req_d     = 1'b0;
            instr_valid_d = 1'b0;
            squash_d      = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q       <= ST_IDLE;
         pc_q          <= RESET_ADDR;
         mem_req_q     <= 1'b0;
         mem_addr_q    <= RESET_ADDR;
         instr_valid_q <= 1'b0;
         instr_q       <= '0;
         instr_pc_q    <= '0;
         squash_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         mem_req_q     <= mem_req_d;
         mem_addr_q    <= mem_addr_d;
         instr_valid_q <= instr_valid_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         squash_q      <= squash_d;
      end
   end

   assign o_mem_req     = mem_req_q;
   assign o_mem_addr    = mem_addr_q;
   assign o_instr_valid = instr_valid_q;
   assign o_instr       = instr_q;
   assign o_instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_sequencer
//
// Bench for pc_fetch_sequencer. A memory responder acks each request after a
// programmable number of extra cycles and returns a word derived from the
// address. Expected request addresses and expected transferred PCs are queued
// when a test is set up and checked as the DUT produces them.
// -----------------------------------------------------------------------------
module tb_pc_fetch_sequencer;

   logic        clk;
   logic        n_rst;
   logic        i_en;
   logic        i_jump;
   logic [31:0] i_jump_addr;
   logic        o_mem_req;
   logic [31:0] o_mem_addr;
   logic        i_mem_ack;
   logic [31:0] i_mem_data;
   logic        o_instr_valid;
   logic [31:0] o_instr;
   logic [31:0] o_instr_pc;
   logic        i_instr_ready;

   pc_fetch_sequencer dut (
      .clk           (clk),
      .n_rst         (n_rst),
      .i_en          (i_en),
      .i_jump        (i_jump),
      .i_jump_addr   (i_jump_addr),
      .o_mem_req     (o_mem_req),
      .o_mem_addr    (o_mem_addr),
      .i_mem_ack     (i_mem_ack),
      .i_mem_data    (i_mem_data),
      .o_instr_valid (o_instr_valid),
      .o_instr       (o_instr),
      .o_instr_pc    (o_instr_pc),
      .i_instr_ready (i_instr_ready)
   );

   int checks  = 0;
   int errors  = 0;
   int cyc     = 0;
   int xfer_cnt = 0;
   int req_cnt = 0;
   int ack_dly = 0;

   logic [31:0] exp_req[$];
   logic [31:0] exp_xfer[$];
   int          xfer_cyc[$];
   logic [31:0] req_addr;

   typedef struct {
      logic        use_jump;
      logic [31:0] start;
      int          ack_dly;
      int          n;
      int          period;
   } vec_t;

   vec_t vecs[4];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out or unexpected event (t=%0t)", name, $time);
   endtask

   // Inputs are driven 2 time units after the falling edge.
   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   // Memory responder: runs on the falling edge.
   initial begin
      i_mem_ack  = 1'b0;
      i_mem_data = 32'h0;
      req_addr   = 32'h0;
      forever begin
         @(negedge clk);
         if (n_rst && o_mem_req) begin
            if (req_cnt == 0) begin
               if (exp_req.size() == 0) begin
                  fail_now("unexpected_request");
               end else begin
                  chk("req_addr", o_mem_addr, exp_req.pop_front());
               end
               req_addr = o_mem_addr;
            end else begin
               chk("req_addr_stable", o_mem_addr, req_addr);
            end
            chk("valid_low_in_fetch", o_instr_valid, 1'b0);
            if (req_cnt == ack_dly) begin
               i_mem_ack  = 1'b1;
               i_mem_data = mem_word(o_mem_addr);
               req_cnt    = 0;
            end else begin
               i_mem_ack  = 1'b0;
               i_mem_data = 32'hDEAD_BEEF;
               req_cnt++;
            end
         end else begin
            i_mem_ack  = 1'b0;
            i_mem_data = 32'hDEAD_BEEF;
            req_cnt    = 0;
         end
      end
   end

   // Decode-side monitor: runs after the inputs for the coming edge are set.
   initial begin
      forever begin
         @(negedge clk);
         #3;
         if (n_rst && o_instr_valid && i_instr_ready) begin
            if (exp_xfer.size() == 0) begin
               fail_now("unexpected_transfer");
            end else begin
               logic [31:0] e;
               e = exp_xfer.pop_front();
               chk("xfer_pc", o_instr_pc, e);
               chk("xfer_instr", o_instr, mem_word(e));
            end
            xfer_cnt++;
            xfer_cyc.push_back(cyc);
         end
      end
   end

   task automatic do_reset();
      tick();
      n_rst  = 1'b0;
      i_en   = 1'b0;
      i_jump = 1'b0;
      i_instr_ready = 1'b1;
      #1;
      chk("rst_mem_req", o_mem_req, 1'b0);
      chk("rst_mem_addr", o_mem_addr, 32'h0);
      chk("rst_valid", o_instr_valid, 1'b0);
      chk("rst_instr", o_instr, 32'h0);
      chk("rst_instr_pc", o_instr_pc, 32'h0);
      tick();
      tick();
      exp_req.delete();
      exp_xfer.delete();
      xfer_cyc.delete();
      xfer_cnt = 0;
      req_cnt  = 0;
      n_rst    = 1'b1;
   endtask

   // Run until the n-th instruction is presented, then drop i_en so the DUT
   // returns to IDLE after that transfer.
   task automatic run_until(input int n, input string name);
      bit done = 1'b0;
      for (int t = 0; t < 400; t++) begin
         tick();
         if (o_instr_valid && i_instr_ready && xfer_cnt == n - 1) begin
            i_en = 1'b0;
            done = 1'b1;
            break;
         end
      end
      if (!done) fail_now(name);
   endtask

   task automatic drain(input string name);
      bit done = 1'b0;
      i_en   = 1'b0;
      i_jump = 1'b0;
      i_instr_ready = 1'b1;
      for (int t = 0; t < 100; t++) begin
         tick();
         if (!o_mem_req && !o_instr_valid) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) fail_now({name, "_drain"});
      chk({name, "_req_left"}, exp_req.size(), 0);
      chk({name, "_xfer_left"}, exp_xfer.size(), 0);
   endtask

   task automatic wait_req(input string name);
      bit done = 1'b0;
      for (int t = 0; t < 100; t++) begin
         tick();
         if (o_mem_req) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) fail_now(name);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      bit          hit;

      vecs[0] = '{1'b0, 32'h0000_0000, 0, 4, 2};
      vecs[1] = '{1'b1, 32'h0000_0010, 2, 3, 4};
      vecs[2] = '{1'b1, 32'hFFFF_FFFE, 0, 3, 2};
      vecs[3] = '{1'b1, 32'h0000_0055, 1, 2, 3};

      n_rst = 1'b0;
      i_en = 1'b0;
      i_jump = 1'b0;
      i_jump_addr = 32'h0;
      i_instr_ready = 1'b1;

      // Table-driven straight-line runs.
      for (int v = 0; v < 4; v++) begin
         do_reset();
         ack_dly = vecs[v].ack_dly;
         if (vecs[v].use_jump) begin
            i_jump = 1'b1;
            i_jump_addr = vecs[v].start;
            tick();
            i_jump = 1'b0;
            tick();
            chk("idle_jump_no_req", o_mem_req, 1'b0);
         end
         for (int k = 0; k < vecs[v].n; k++) begin
            a = vecs[v].start + 32'(k);
            exp_req.push_back(a);
            exp_xfer.push_back(a);
         end
         i_en = 1'b1;
         run_until(vecs[v].n, "vec_run");
         drain("vec");
         chk("vec_xfer_count", xfer_cnt, vecs[v].n);
         for (int k = 1; k < xfer_cyc.size(); k++)
            chk("vec_period", xfer_cyc[k] - xfer_cyc[k-1], vecs[v].period);
      end

      // Jump on the ack edge of address 5: its data must never reach decode.
      do_reset();
      ack_dly = 0;
      for (int k = 0; k <= 5; k++) exp_req.push_back(32'(k));
      exp_req.push_back(32'h100);
      exp_req.push_back(32'h101);
      for (int k = 0; k <= 4; k++) exp_xfer.push_back(32'(k));
      exp_xfer.push_back(32'h100);
      exp_xfer.push_back(32'h101);
      i_en = 1'b1;
      hit = 1'b0;
      for (int t = 0; t < 100; t++) begin
         tick();
         if (o_mem_req && o_mem_addr == 32'd5 && i_mem_ack) begin
            i_jump = 1'b1;
            i_jump_addr = 32'h100;
            tick();
            i_jump = 1'b0;
            hit = 1'b1;
            break;
         end
      end
      if (!hit) fail_now("squash_ack_wait");
      run_until(7, "squash_run");
      drain("squash");

      // Decode stalls 4 cycles, then a jump to 0x40 drops the instruction.
      do_reset();
      ack_dly = 0;
      exp_req.push_back(32'h0);
      exp_req.push_back(32'h40);
      exp_xfer.push_back(32'h40);
      i_instr_ready = 1'b0;
      i_en = 1'b1;
      hit = 1'b0;
      for (int t = 0; t < 50; t++) begin
         tick();
         if (o_instr_valid) begin
            hit = 1'b1;
            break;
         end
      end
      if (!hit) fail_now("stall_wait_valid");
      for (int k = 0; k < 4; k++) begin
         chk("stall_valid", o_instr_valid, 1'b1);
         chk("stall_instr", o_instr, mem_word(32'h0));
         chk("stall_pc", o_instr_pc, 32'h0);
         if (k < 3) tick();
      end
      i_jump = 1'b1;
      i_jump_addr = 32'h40;
      tick();
      i_jump = 1'b0;
      i_instr_ready = 1'b1;
      chk("drop_valid", o_instr_valid, 1'b0);
      chk("drop_req", o_mem_req, 1'b1);
      chk("drop_req_addr", o_mem_addr, 32'h40);
      run_until(1, "drop_run");
      drain("drop");

      // Jump on the same edge as a transfer: instruction 2 is consumed.
      do_reset();
      ack_dly = 0;
      for (int k = 0; k <= 2; k++) begin
         exp_req.push_back(32'(k));
         exp_xfer.push_back(32'(k));
      end
      exp_req.push_back(32'h80);
      exp_xfer.push_back(32'h80);
      i_en = 1'b1;
      hit = 1'b0;
      for (int t = 0; t < 50; t++) begin
         tick();
         if (o_instr_valid && o_instr_pc == 32'd2) begin
            i_jump = 1'b1;
            i_jump_addr = 32'h80;
            tick();
            i_jump = 1'b0;
            hit = 1'b1;
            break;
         end
      end
      if (!hit) fail_now("xfer_jump_wait");
      run_until(4, "xfer_jump_run");
      drain("xfer_jump");

      // Two jumps during one slow fetch: the later target wins.
      do_reset();
      ack_dly = 3;
      exp_req.push_back(32'h0);
      exp_req.push_back(32'h30);
      exp_xfer.push_back(32'h30);
      i_en = 1'b1;
      wait_req("multi_jump_wait");
      i_jump = 1'b1;
      i_jump_addr = 32'h20;
      tick();
      i_jump_addr = 32'h30;
      tick();
      i_jump = 1'b0;
      run_until(1, "multi_jump_run");
      drain("multi_jump");

      // Asynchronous reset pulse between edges while a request is pending.
      do_reset();
      ack_dly = 5;
      exp_req.push_back(32'h0);
      exp_req.push_back(32'h0);
      exp_req.push_back(32'h1);
      exp_xfer.push_back(32'h0);
      exp_xfer.push_back(32'h1);
      i_en = 1'b1;
      wait_req("arst_wait");
      tick();
      n_rst = 1'b0;
      #1;
      chk("arst_mem_req", o_mem_req, 1'b0);
      chk("arst_mem_addr", o_mem_addr, 32'h0);
      chk("arst_valid", o_instr_valid, 1'b0);
      #1;
      req_cnt = 0;
      ack_dly = 0;
      n_rst = 1'b1;
      run_until(2, "arst_run");
      drain("arst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_fetch_sequencer.md
PC_FETCH_SEQUENCER -- requirements
Module: pc_fetch_sequencer

Interface
REQ-001 Parameters SHALL be: WIDTH, default 32, address width; IWIDTH, default 32, instruction width; RESET_ADDR, default 0, first fetch address.
REQ-002 clk  input  1  clock; all state changes on its rising edge.
REQ-003 n_rst  input  1  reset, asynchronous, active-low.
REQ-004 i_en  input  1  run enable; when low, no new fetch requests are issued.
REQ-005 i_jump  input  1  redirect request, sampled each rising edge.
REQ-006 i_jump_addr  input  WIDTH  redirect target, valid with i_jump.
REQ-007 o_mem_req  output  1  instruction-memory request.
REQ-008 o_mem_addr  output  WIDTH  fetch address.
REQ-009 i_mem_ack  input  1  memory completion; meaningful only while o_mem_req=1.
REQ-010 i_mem_data  input  IWIDTH  instruction word, valid with i_mem_ack.
REQ-011 o_instr_valid  output  1  instruction presented to decode.
REQ-012 o_instr  output  IWIDTH  presented instruction.
REQ-013 o_instr_pc  output  WIDTH  address of presented instruction.
REQ-014 i_instr_ready  input  1  decode accepts; transfer when o_instr_valid and i_instr_ready are both 1 on a rising edge.

Function
REQ-015 The block SHALL hold an internal PC register and FSM with states IDLE, FETCH, HOLD; all outputs SHALL be registered.
REQ-016 IDLE: on an edge with i_en=1, go to FETCH, with o_mem_req=1 and o_mem_addr=PC from the next cycle.
REQ-017 FETCH: o_mem_req and o_mem_addr SHALL stay constant until an edge samples i_mem_ack=1 (ack allowed in the first request cycle); the request is never withdrawn early.
REQ-018 On ack with no squash pending: capture i_mem_data into o_instr and o_mem_addr into o_instr_pc, set o_instr_valid=1, drop o_mem_req, PC <= PC+1, go to HOLD.
REQ-019 PC increment SHALL be modulo 2^WIDTH; all-ones wraps to 0 with no flag.
REQ-020 HOLD: o_instr, o_instr_pc and o_instr_valid SHALL stay stable until transfer; on transfer, clear o_instr_valid and go to FETCH if i_en=1, else IDLE.
REQ-021 Steady-state throughput SHALL be one instruction per 2 cycles with zero-wait memory and decode always ready.
REQ-022 Jump in IDLE: PC <= i_jump_addr; no other effect.
REQ-023 Jump in FETCH (including the ack edge): latch target and set squash; the in-flight transaction completes normally; its data SHALL be discarded (o_instr_valid stays 0); the next request SHALL use the target, with PC <= target+1 after that fetch's ack.
REQ-024 Repeated jumps while squash is pending: the last sampled target wins.
REQ-025 Jump in HOLD without transfer: clear o_instr_valid next cycle (instruction dropped), PC <= target, go to FETCH (IDLE if i_en=0).
REQ-026 Jump in HOLD with a transfer on the same edge: the transfer completes (instruction consumed); the next fetch uses the target.
REQ-027 i_en low in FETCH: finish the transaction, enter HOLD as normal, then IDLE after transfer; i_en is ignored while a request is in flight.

Reset
REQ-028 While n_rst=0: state=IDLE, PC=RESET_ADDR, o_mem_req=0, o_mem_addr=RESET_ADDR, o_instr_valid=0, o_instr=0, o_instr_pc=0, squash cleared, independent of clk.
REQ-029 Reset asserted mid-transaction SHALL abandon it; the memory is required to tolerate a dropped request.
REQ-030 After n_rst deasserts, the first request SHALL be to RESET_ADDR.

Verification
REQ-031 Reset release, i_en=1, ack every request cycle, ready=1 -> o_instr_pc sequence 0,1,2,3 at one instruction per 2 cycles.
REQ-032 3-cycle ack delay -> o_mem_addr held constant for all 3 request cycles; o_instr_valid is 0 until the ack edge.
REQ-033 Jump to 0x100 in the same cycle as the ack of address 5 -> address 5 is never presented; next o_mem_addr=0x100, then 0x101.
REQ-034 In HOLD with ready=0 for 4 cycles, then a jump to 0x40 -> presented instruction dropped; next fetch at 0x40; o_instr stable across the 4 stall cycles.
REQ-035 PC=2^WIDTH-1 fetched and accepted -> next o_mem_addr=0.
REQ-036 n_rst pulsed low mid-FETCH between clock edges -> o_mem_req=0 immediately; after release, the next request is to RESET_ADDR.
